reg_file: RTL and testbench

//   32-entry x 32-bit general-purpose register file for the Dioptase pipeline decode stage.

---
 rtl/reg_file.sv | 79 +++++++
 tb/tb_reg_file.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 32 x 32-bit register file with two registered read ports, two write ports,
// write-to-read bypass and a hardwired-zero r0.
module reg_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr_1,
    output logic [31:0] rdata_1,
    input  logic [4:0]  raddr_2,
    output logic [31:0] rdata_2,
    input  logic        we_1,
    input  logic [4:0]  waddr_1,
    input  logic [31:0] wdata_1,
    input  logic        we_2,
    input  logic [4:0]  waddr_2,
    input  logic [31:0] wdata_2,
    input  logic        stall,
    output logic [31:0] ret_val
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] rdata_1_q, rdata_1_d;
    logic [31:0] rdata_2_q, rdata_2_d;

    logic wr_1, wr_2;
    assign wr_1 = we_1 && (waddr_1 != 5'd0);
    assign wr_2 = we_2 && (waddr_2 != 5'd0);

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_2) regs_d[waddr_2] = wdata_2;
        if (wr_1) regs_d[waddr_1] = wdata_1;
        regs_d[0] = 32'd0;
    end

    function automatic logic [31:0] read_val(input logic [4:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a != 5'd0) begin
            if (we_1 && waddr_1 == a)      v = wdata_1;
            else if (we_2 && waddr_2 == a) v = wdata_2;
            else                           v = regs_q[a];
        end
        return v;
    endfunction

    always_comb begin
        rdata_1_d = rdata_1_q;
        rdata_2_d = rdata_2_q;
        if (!stall) begin
            rdata_1_d = read_val(raddr_1);
            rdata_2_d = read_val(raddr_2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            rdata_1_q <= 32'd0;
            rdata_2_q <= 32'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rdata_1_q <= rdata_1_d;
            rdata_2_q <= rdata_2_d;
        end
    end

    assign rdata_1 = rdata_1_q;
    assign rdata_2 = rdata_2_q;
    assign ret_val = regs_q[1];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios plus random traffic against an
// array-based reference model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  raddr_1, raddr_2, waddr_1, waddr_2;
    logic [31:0] rdata_1, rdata_2, wdata_1, wdata_2, ret_val;
    logic        we_1, we_2, stall;

    always #5 clk = ~clk;

    reg_file dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_1 (raddr_1),
        .rdata_1 (rdata_1),
        .raddr_2 (raddr_2),
        .rdata_2 (rdata_2),
        .we_1    (we_1),
        .waddr_1 (waddr_1),
        .wdata_1 (wdata_1),
        .we_2    (we_2),
        .waddr_2 (waddr_2),
        .wdata_2 (wdata_2),
        .stall   (stall),
        .ret_val (ret_val)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] mem [32];
    logic [31:0] m_rd1, m_rd2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // What a read of address a should see given the writes presented this cycle.
    function automatic logic [31:0] mval(input logic [4:0] a, input logic w1, input logic [4:0] a1,
                                         input logic [31:0] d1, input logic w2,
                                         input logic [4:0] a2, input logic [31:0] d2);
        if (a == 0) return 32'd0;
        if (w1 && a1 == a) return d1;
        if (w2 && a2 == a) return d2;
        return mem[a];
    endfunction

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cyc(input string tag, input logic rst, input logic w1, input logic [4:0] a1,
                       input logic [31:0] d1, input logic w2, input logic [4:0] a2,
                       input logic [31:0] d2, input logic [4:0] r1, input logic [4:0] r2,
                       input logic st);
        logic [31:0] e1, e2;
        rst_n = rst; we_1 = w1; waddr_1 = a1; wdata_1 = d1;
        we_2 = w2; waddr_2 = a2; wdata_2 = d2;
        raddr_1 = r1; raddr_2 = r2; stall = st;
        e1 = st ? m_rd1 : mval(r1, w1, a1, d1, w2, a2, d2);
        e2 = st ? m_rd2 : mval(r2, w1, a1, d1, w2, a2, d2);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
            m_rd1 = 32'd0;
            m_rd2 = 32'd0;
        end else begin
            m_rd1 = e1;
            m_rd2 = e2;
            if (w2 && a2 != 0) mem[a2] = d2;
            if (w1 && a1 != 0) mem[a1] = d1;
        end
        @(negedge clk);
        check({tag, "_rd1"}, rdata_1, m_rd1);
        check({tag, "_rd2"}, rdata_2, m_rd2);
        check({tag, "_ret"}, ret_val, mem[1]);
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst_n = 1'b0; we_1 = 0; we_2 = 0; waddr_1 = 0; waddr_2 = 0;
        wdata_1 = 0; wdata_2 = 0; raddr_1 = 0; raddr_2 = 0; stall = 0;
        @(negedge clk);
        cyc("init_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset after arbitrary writes, with writes and stall asserted during reset.
        cyc("pre_w", 1, 1, 1, 32'hCAFE0001, 1, 12, 32'h0BADF00D, 12, 1, 0);
        cyc("rst", 0, 1, 2, 32'h5, 1, 3, 32'h6, 1, 2, 1);
        check("rst_rd1_zero", rdata_1, 32'd0);
        check("rst_ret_zero", ret_val, 32'd0);
        for (int i = 0; i < 32; i += 2)
            cyc("rst_scan", 1, 0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 1), 0);

        // Write then read next cycle.
        cyc("wr5", 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        cyc("rd5", 1, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        check("wr_rd_r5", rdata_1, 32'hDEADBEEF);

        // r0 discard and write collision.
        cyc("wr_r0", 1, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0);
        cyc("coll", 1, 1, 7, 32'hAAAA, 1, 7, 32'h5555, 0, 0, 0);
        cyc("rd_r0_r7", 1, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        check("r0_zero", rdata_1, 32'd0);
        check("coll_r7", rdata_2, 32'hAAAA);

        // Same-cycle bypass.
        cyc("byp", 1, 0, 0, 0, 1, 9, 32'h42, 0, 9, 0);
        check("bypass_r9", rdata_2, 32'h42);

        // Stall holds read data while writes still land.
        cyc("st_w3", 1, 1, 3, 32'h11, 0, 0, 0, 0, 0, 0);
        cyc("st_r3", 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        check("stall_pre", rdata_1, 32'h11);
        cyc("st_hold", 1, 1, 3, 32'h22, 0, 0, 0, 4, 5, 1);
        check("stall_hold", rdata_1, 32'h11);
        cyc("st_rel", 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        check("stall_release", rdata_1, 32'h22);

        // ret_val tracks r1 from either write port.
        cyc("ret1", 1, 1, 1, 32'd99, 0, 0, 0, 0, 0, 0);
        check("ret_p1", ret_val, 32'd99);
        cyc("ret2", 1, 0, 0, 0, 1, 1, 32'd1234567, 0, 0, 0);
        check("ret_p2", ret_val, 32'd1234567);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc("rnd", ($urandom_range(0, 99) != 0),
                1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
                1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
                rnd_addr(), rnd_addr(), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
